// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode, funct3, ALU-op, write-back and store-size definitions
package rv32i_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    WB_ALU, WB_MEM, WB_PC4, WB_IMMU, WB_PC_IMMU
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_BYTE = 2'b01,
    ST_HALF = 2'b10,
    ST_WORD = 2'b11
  } st_size_e;

  // alt is instruction bit 30; SUB only exists in the register form
  function automatic alu_op_e alu_op_decode(input logic [2:0] f3, input logic alt,
                                            input logic is_reg);
    case (f3)
      F3_ADD_SUB: return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SR:      return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, two async read ports, one sync write port
module regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] Registers [0:31];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) Registers[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      Registers[waddr_i] <= wdata_i;
    end
  end

  // No bypass: a same-cycle write is visible only after the edge
  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : Registers[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : Registers[raddr2_i];

endmodule

// File: rtl/cpu_top.sv
// rtl/cpu_top.sv - single-cycle RV32I core: decode, ALU, branch, load extract, PC
module cpu_top
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] data,
  output logic [31:0] pc,
  output logic [31:0] rd_data,
  output logic [31:0] Read_data_2,
  output logic        MemREAD,
  output logic [1:0]  MemWrite
);

  logic [31:0] pc_q, pc_d;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, op_b, alu_res, load_val, wb_val;
  logic [31:0] pc_plus4, jalr_tgt;

  alu_op_e  alu_op;
  wb_sel_e  wb_sel;
  st_size_e st_size;
  logic     use_imm, use_imm_s, reg_write, mem_read, is_branch, is_jal, is_jalr, taken;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'd0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  always_comb begin
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    st_size   = ST_NONE;
    use_imm   = 1'b0;
    use_imm_s = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_op    = alu_op_decode(funct3, instruction[30], 1'b1);
        reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        alu_op    = alu_op_decode(funct3, instruction[30], 1'b0);
        use_imm   = 1'b1;
        reg_write = 1'b1;
      end
      OPC_LOAD: begin
        use_imm   = 1'b1;
        mem_read  = 1'b1;
        reg_write = 1'b1;
        wb_sel    = WB_MEM;
      end
      OPC_STORE: begin
        use_imm   = 1'b1;
        use_imm_s = 1'b1;
        case (funct3)
          F3_SB:   st_size = ST_BYTE;
          F3_SH:   st_size = ST_HALF;
          F3_SW:   st_size = ST_WORD;
          default: st_size = ST_NONE;
        endcase
      end
      OPC_BRANCH: is_branch = 1'b1;
      OPC_JAL: begin
        is_jal    = 1'b1;
        reg_write = 1'b1;
        wb_sel    = WB_PC4;
      end
      OPC_JALR: begin
        is_jalr   = 1'b1;
        use_imm   = 1'b1;
        reg_write = 1'b1;
        wb_sel    = WB_PC4;
      end
      OPC_LUI: begin
        reg_write = 1'b1;
        wb_sel    = WB_IMMU;
      end
      OPC_AUIPC: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC_IMMU;
      end
      default: ;
    endcase
  end

  assign op_b = use_imm ? (use_imm_s ? imm_s : imm_i) : rs2_val;

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      ALU_ADD:  alu_res = rs1_val + op_b;
      ALU_SUB:  alu_res = rs1_val - op_b;
      ALU_SLL:  alu_res = rs1_val << op_b[4:0];
      ALU_SLT:  alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'd0, rs1_val < op_b};
      ALU_XOR:  alu_res = rs1_val ^ op_b;
      ALU_SRL:  alu_res = rs1_val >> op_b[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(rs1_val) >>> op_b[4:0]);
      ALU_OR:   alu_res = rs1_val | op_b;
      ALU_AND:  alu_res = rs1_val & op_b;
      default:  alu_res = 32'd0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_val == rs2_val);
      F3_BNE:  taken = (rs1_val != rs2_val);
      F3_BLT:  taken = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: taken = (rs1_val < rs2_val);
      F3_BGEU: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  // Misaligned halves use only address bit 1; words ignore the low bits
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = data[8*rd_data[1:0] +: 8];
    half_sel = rd_data[1] ? data[31:16] : data[15:0];
    case (funct3)
      F3_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_val = {24'd0, byte_sel};
      F3_LHU:  load_val = {16'd0, half_sel};
      default: load_val = data;
    endcase
  end

  assign pc_plus4 = pc_q + 32'd4;
  assign jalr_tgt = alu_res & ~32'd1;

  always_comb begin
    wb_val = alu_res;
    case (wb_sel)
      WB_MEM:     wb_val = load_val;
      WB_PC4:     wb_val = pc_plus4;
      WB_IMMU:    wb_val = imm_u;
      WB_PC_IMMU: wb_val = pc_q + imm_u;
      default:    wb_val = alu_res;
    endcase
  end

  always_comb begin
    pc_d = pc_plus4;
    if (is_jal)                  pc_d = pc_q + imm_j;
    else if (is_jalr)            pc_d = jalr_tgt;
    else if (is_branch && taken) pc_d = pc_q + imm_b;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= 32'd0;
    else     pc_q <= pc_d;
  end

  regfile regfile (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (reg_write && !rst),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .waddr_i  (rd),
    .wdata_i  (wb_val),
    .rdata1_o (rs1_val),
    .rdata2_o (rs2_val)
  );

  assign pc          = pc_q;
  assign rd_data     = alu_res;
  assign Read_data_2 = rs2_val;
  assign MemREAD     = mem_read && !rst;
  assign MemWrite    = rst ? 2'b00 : st_size;

endmodule

// File: tb/tb_cpu_top.sv
// tb/tb_cpu_top.sv - directed scoreboard bench for cpu_top
module tb_cpu_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, data;
  logic [31:0] pc, rd_data, Read_data_2;
  logic        MemREAD;
  logic [1:0]  MemWrite;

  cpu_top dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .data        (data),
    .pc          (pc),
    .rd_data     (rd_data),
    .Read_data_2 (Read_data_2),
    .MemREAD     (MemREAD),
    .MemWrite    (MemWrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
  endtask

  function automatic logic [31:0] rf(input int n);
    return dut.regfile.Registers[n];
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] d);
    instruction = ins;
    data        = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(enc_s(32'd0, 5'd3, 5'd0, 3'b010), 32'd0);
    push_exp("rst_memwrite", 32'd0);
    check({30'd0, MemWrite});
    tick();
    push_exp("rst_pc", 32'd0);
    check(pc);
    drive(enc_i(32'd0, 5'd0, 3'b010, 5'd8, 7'b0000011), 32'd0);
    push_exp("rst_memread", 32'd0);
    check({31'd0, MemREAD});
    tick();
    rst = 1'b0;

    drive(enc_i(32'd10, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'd0); tick();
    drive(enc_i(32'd20, 5'd0, 3'b000, 5'd2, 7'b0010011), 32'd0); tick();
    drive(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3), 32'd0);
    push_exp("x1", 32'hA); push_exp("x2", 32'h14); push_exp("x3", 32'h1E); push_exp("pc_12", 32'd12);
    tick();
    check(rf(1)); check(rf(2)); check(rf(3)); check(pc);

    drive({20'h12345, 5'd5, 7'b0110111}, 32'd0); tick();
    drive(enc_i(32'd5, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'd0);
    push_exp("lui_x5", 32'h12345000); push_exp("x0_zero", 32'd0);
    tick();
    check(rf(5)); check(rf(0));

    drive(enc_s(32'd0, 5'd3, 5'd0, 3'b010), 32'd0);
    push_exp("sw_memwrite", 32'd3); push_exp("sw_addr", 32'd0); push_exp("sw_data", 32'h1E);
    check({30'd0, MemWrite}); check(rd_data); check(Read_data_2);
    tick();
    drive(enc_i(32'd0, 5'd0, 3'b010, 5'd8, 7'b0000011), 32'h1E);
    push_exp("lw_memread", 32'd1); push_exp("lw_x8", 32'h1E);
    check({31'd0, MemREAD});
    tick();
    check(rf(8));

    drive(enc_i(32'hFFFF_FFFF, 5'd0, 3'b000, 5'd9, 7'b0010011), 32'd0); tick();
    drive(enc_i(32'd1, 5'd0, 3'b000, 5'd10, 7'b0010011), 32'd0); tick();
    drive(enc_b(32'd8, 5'd1, 5'd1, 3'b000), 32'd0);
    push_exp("beq_taken", 32'd44);
    tick(); check(pc);
    drive(enc_b(32'd16, 5'd1, 5'd1, 3'b001), 32'd0);
    push_exp("bne_not_taken", 32'd48);
    tick(); check(pc);
    drive(enc_b(32'd16, 5'd10, 5'd9, 3'b110), 32'd0);
    push_exp("bltu_not_taken", 32'd52);
    tick(); check(pc);
    drive(enc_b(32'd12, 5'd10, 5'd9, 3'b100), 32'd0);
    push_exp("blt_taken", 32'h40);
    tick(); check(pc);

    drive(enc_j(32'd8, 5'd1), 32'd0);
    push_exp("jal_link", 32'h44); push_exp("jal_pc", 32'h48);
    tick(); check(rf(1)); check(pc);
    drive(enc_i(32'h100, 5'd0, 3'b000, 5'd6, 7'b0010011), 32'd0); tick();
    drive(enc_i(32'h21, 5'd6, 3'b000, 5'd0, 7'b1100111), 32'd0);
    push_exp("jalr_pc", 32'h120); push_exp("jalr_x0", 32'd0);
    tick(); check(pc); check(rf(0));

    drive({20'h00001, 5'd20, 7'b0110111}, 32'd0); tick();
    drive(enc_s(32'd3, 5'd2, 5'd20, 3'b000), 32'd0);
    push_exp("sb_memwrite", 32'd1); push_exp("sb_addr", 32'h1003); push_exp("sb_data", 32'h14);
    check({30'd0, MemWrite}); check(rd_data); check(Read_data_2);
    tick();
    drive(enc_i(32'd3, 5'd20, 3'b000, 5'd11, 7'b0000011), 32'h8012_3456);
    push_exp("lb_sext", 32'hFFFF_FF80);
    tick(); check(rf(11));
    drive(enc_i(32'd3, 5'd20, 3'b100, 5'd12, 7'b0000011), 32'h8012_3456);
    push_exp("lbu_zext", 32'h80);
    tick(); check(rf(12));

    drive(enc_i(32'h404, 5'd11, 3'b101, 5'd13, 7'b0010011), 32'd0);
    push_exp("srai", 32'hFFFF_FFF8);
    tick(); check(rf(13));
    drive(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd14), 32'd0);
    push_exp("sub", 32'h30);
    tick(); check(rf(14));
    drive(enc_i(32'd1, 5'd9, 3'b010, 5'd16, 7'b0010011), 32'd0);
    push_exp("slti", 32'd1);
    tick(); check(rf(16));
    drive(enc_i(32'd1, 5'd9, 3'b011, 5'd15, 7'b0010011), 32'd0);
    push_exp("sltiu", 32'd0); push_exp("pc_seq", 32'h140);
    tick(); check(rf(15)); check(pc);

    rst = 1'b1;
    drive(enc_s(32'd0, 5'd3, 5'd0, 3'b010), 32'd0);
    push_exp("midrst_memwrite", 32'd0);
    check({30'd0, MemWrite});
    push_exp("midrst_pc", 32'd0);
    for (int i = 0; i < 32; i++) push_exp($sformatf("midrst_x%0d", i), 32'd0);
    tick();
    check(pc);
    for (int i = 0; i < 32; i++) check(rf(i));
    rst = 1'b0;

    drive(enc_i(32'd7, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'd0);
    push_exp("post_rst_x1", 32'd7); push_exp("post_rst_pc", 32'd4);
    tick(); check(rf(1)); check(pc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
